alu_share_arbiter: RTL and testbench

//   Shares one ALU between N_REQ processor cores of the multiprocessor top level.

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/alu_share_arbiter_if.sv | 39 +++
 rtl/rr_pick.sv | 38 +++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared constants for the ALU-sharing arbiter: FSM encodings, flag bit
// positions inside the {N,Z,C,V} flag word, and the opcodes the ALU decodes.
// Purpose: common definitions. Latency: n/a. Backpressure: n/a.
package alu_share_pkg;

  // FSM encodings: IDLE -> WAIT -> RESP -> IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Flag bit indices within the flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes understood by the shared ALU
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of core-side request/response signals and ALU-side operand/result
// signals shared between the arbiter (slave) and the cores + ALU (master).
// Purpose: port grouping. Latency: n/a. Backpressure: grant held per operation.
//   req/req_a/req_b/req_op : per-core request level and packed operand fields
//   gnt/rsp_valid          : one-hot grant and one-cycle response pulse
//   result/flags/busy      : last captured ALU output, arbiter activity
//   alu_a/alu_b/alu_op     : registered operands towards the ALU
//   alu_result/alu_flags   : ALU outputs back to the arbiter
interface alu_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       result;
  logic [FLAG_W-1:0]       flags;
  logic                    busy;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_W-1:0]       alu_result;
  logic [FLAG_W-1:0]       alu_flags;

  modport master (
    output req, req_a, req_b, req_op, alu_result, alu_flags,
    input  gnt, rsp_valid, result, flags, busy, alu_a, alu_b, alu_op
  );

  modport slave (
    input  req, req_a, req_b, req_op, alu_result, alu_flags,
    output gnt, rsp_valid, result, flags, busy, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit searching from ptr upwards, modulo N.
// Latency: combinational. Backpressure: none; any=0 when no request is set.
//   req    : request vector        ptr : search start index
//   onehot : one-hot winner        idx : binary winner index   any : |req
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic found;
  int   pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      // Wrap explicitly so non-power-of-two N works too
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ cores: round-robin grant, latch operands, wait, return result.
// Latency: rsp_valid ALU_LAT cycles after grant; one op per ALU_LAT+2 cycles.
// Backpressure: gnt held for the whole op; other requesters wait, no arbitration outside IDLE.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of alu_share_arbiter_if (core requests/responses, ALU operands/results)
// ALU_LAT must be >= 1; a zero-latency ALU is not supported.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int FLAG_W  = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [IDX_W-1:0]  ptr_q,    ptr_d;
  logic [N_REQ-1:0]  gnt_q,    gnt_d;
  logic [N_REQ-1:0]  rsp_q,    rsp_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] flags_q,  flags_d;
  logic [DATA_W-1:0] a_q,      a_d;
  logic [DATA_W-1:0] b_q,      b_d;
  logic [OP_W-1:0]   op_q,     op_d;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    rsp_d    = '0;          // rsp_valid is only ever a single-cycle pulse
    result_d = result_q;    // result/flags persist until the next capture
    flags_d  = flags_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          a_d     = bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];
          b_d     = bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];
          op_d    = bus.req_op[int'(pick_idx)*OP_W +: OP_W];
          cnt_d   = CNT_W'(ALU_LAT);
          // Winner moves to the back of the queue for the next arbitration
          ptr_d   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
          state_d = S_WAIT;
        end else begin
          gnt_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = bus.alu_result;
          flags_d  = bus.alu_flags;
          rsp_d    = gnt_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rsp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rsp_q    <= rsp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each fed by a behavioural ALU; directed vectors, corner sequences, random ops.
// Latency: n/a. Backpressure: n/a.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) bus1 ();
  alu_share_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) bus3 ();

  alu_share_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .FLAG_W(FW), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1));
  alu_share_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .FLAG_W(FW), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(bus3));

  // Behavioural ALU: returns {N,Z,C,V, result}; SUB carry means borrow
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic [3:0] fl;
    s = {1'b0, a} + {1'b0, b};
    r = 8'h00;
    fl = 4'h0;
    case (op)
      OP_ADD: begin
        r = s[7:0];
        fl[FLAG_C] = s[8];
        fl[FLAG_V] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        r = a - b;
        fl[FLAG_C] = (a < b);
        fl[FLAG_V] = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
    fl[FLAG_N] = r[7];
    fl[FLAG_Z] = (r == 8'h00);
    return {fl, r};
  endfunction

  // Stimulus registers, index 0 -> dut1, index 1 -> dut3
  logic [N-1:0]    t_req [2];
  logic [N*DW-1:0] t_a   [2];
  logic [N*DW-1:0] t_b   [2];
  logic [N*OW-1:0] t_op  [2];

  assign bus1.req = t_req[0];  assign bus1.req_a = t_a[0];
  assign bus1.req_b = t_b[0];  assign bus1.req_op = t_op[0];
  assign bus3.req = t_req[1];  assign bus3.req_a = t_a[1];
  assign bus3.req_b = t_b[1];  assign bus3.req_op = t_op[1];

  logic [11:0] alu1, alu3;
  assign alu1 = alu_ref(bus1.alu_a, bus1.alu_b, bus1.alu_op);
  assign alu3 = alu_ref(bus3.alu_a, bus3.alu_b, bus3.alu_op);
  assign bus1.alu_result = alu1[7:0];  assign bus1.alu_flags = alu1[11:8];
  assign bus3.alu_result = alu3[7:0];  assign bus3.alu_flags = alu3[11:8];

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] rsp;
    logic [7:0] result;
    logic [3:0] flags;
    logic       busy;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } obs_t;

  obs_t ob [2];
  assign ob[0] = {bus1.gnt, bus1.rsp_valid, bus1.result, bus1.flags, bus1.busy,
                  bus1.alu_a, bus1.alu_b, bus1.alu_op};
  assign ob[1] = {bus3.gnt, bus3.rsp_valid, bus3.result, bus3.flags, bus3.busy,
                  bus3.alu_a, bus3.alu_b, bus3.alu_op};

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_core(input int s, input int c, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] op);
    t_a[s][c*DW +: DW]  = a;
    t_b[s][c*DW +: DW]  = b;
    t_op[s][c*OW +: OW] = op;
  endtask

  task automatic scramble(input int s);
    t_a[s]  = $urandom;
    t_b[s]  = $urandom;
    t_op[s] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst1 = 1'b1;
    rst3 = 1'b1;
    t_req[0] = '0;
    t_req[1] = '0;
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;
    m_ptr[0] = 0;
    m_ptr[1] = 0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [3:0] gnt;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  // Single operation on dut1 (ALU_LAT=1); winner slot gets the vector operands
  task automatic run_vec(input vec_t v, input int id);
    int w;
    w = 0;
    for (int c = 0; c < N; c++) begin
      set_core(0, c, 8'hA0 + 8'(c), 8'h50 + 8'(c), OP_OR);
      if (v.gnt[c]) w = c;
    end
    set_core(0, w, v.a, v.b, v.op);
    t_req[0] = v.req;
    step();
    chk($sformatf("v%0d gnt", id), ob[0].gnt, v.gnt);
    chk($sformatf("v%0d operands", id), {ob[0].a, ob[0].b, ob[0].op}, {v.a, v.b, v.op});
    chk($sformatf("v%0d busy/rsp", id), {ob[0].busy, ob[0].rsp}, {1'b1, 4'b0000});
    step();
    chk($sformatf("v%0d rsp_valid", id), ob[0].rsp, v.gnt);
    chk($sformatf("v%0d result/flags", id), {ob[0].result, ob[0].flags}, {v.res, v.fl});
    chk($sformatf("v%0d gnt held", id), ob[0].gnt, v.gnt);
    t_req[0] = '0;
    step();
    chk($sformatf("v%0d idle", id), {ob[0].gnt, ob[0].rsp, ob[0].busy}, 9'b0);
    chk($sformatf("v%0d result held", id), {ob[0].result, ob[0].flags}, {v.res, v.fl});
  endtask

  // Random operations checked against round-robin arithmetic and the ALU model
  task automatic run_rand(input int s, input int lat, input int n);
    logic [3:0]  m, oh;
    logic [7:0]  ea, eb;
    logic [3:0]  eo;
    logic [11:0] er;
    int          w, pos;
    for (int t = 0; t < n; t++) begin
      scramble(s);
      m = 4'($urandom_range(0, 15));
      if (t % 5 == 0) m = 4'hF;
      t_req[s] = m;
      w = -1;
      for (int k = 0; k < N; k++) begin
        pos = (m_ptr[s] + k) % N;
        if (w < 0 && m[pos]) w = pos;
      end
      if (w < 0) begin
        step();
        chk($sformatf("r%0d.%0d no req", s, t), {ob[s].gnt, ob[s].busy}, 5'b0);
        continue;
      end
      oh = 4'(1 << w);
      ea = t_a[s][w*DW +: DW];
      eb = t_b[s][w*DW +: DW];
      eo = t_op[s][w*OW +: OW];
      er = alu_ref(ea, eb, eo);
      step();
      chk($sformatf("r%0d.%0d gnt", s, t), ob[s].gnt, oh);
      chk($sformatf("r%0d.%0d operands", s, t), {ob[s].a, ob[s].b, ob[s].op}, {ea, eb, eo});
      for (int c = 1; c <= lat; c++) begin
        scramble(s);
        t_req[s] = 4'($urandom);
        step();
        if (c < lat)
          chk($sformatf("r%0d.%0d wait", s, t), {ob[s].gnt, ob[s].rsp, ob[s].busy}, {oh, 4'b0, 1'b1});
        else begin
          chk($sformatf("r%0d.%0d rsp", s, t), {ob[s].gnt, ob[s].rsp}, {oh, oh});
          chk($sformatf("r%0d.%0d result", s, t), {ob[s].flags, ob[s].result}, er);
        end
      end
      t_req[s] = t_req[s] & ~oh;
      step();
      chk($sformatf("r%0d.%0d idle", s, t), {ob[s].gnt, ob[s].rsp, ob[s].busy}, 9'b0);
      m_ptr[s] = (w + 1) % N;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached limit 500000 without finishing", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t       vt [6];
    logic [3:0] gl [5];
    int         gc [5];
    logic [3:0] ge [5];
    logic [3:0] prev, raise;
    int         ng;
    logic       seen;

    vt[0] = '{4'b0001, 8'h05, 8'h03, OP_ADD, 4'b0001, 8'h08, 4'b0000};
    vt[1] = '{4'b0100, 8'hFF, 8'h01, OP_ADD, 4'b0100, 8'h00, 4'b0110};
    vt[2] = '{4'b1001, 8'h05, 8'h03, OP_SUB, 4'b1000, 8'h02, 4'b0000};
    vt[3] = '{4'b0110, 8'h03, 8'h05, OP_SUB, 4'b0010, 8'hFE, 4'b1010};
    vt[4] = '{4'b0011, 8'h7F, 8'h01, OP_ADD, 4'b0001, 8'h80, 4'b1001};
    vt[5] = '{4'b1110, 8'h80, 8'h01, OP_SUB, 4'b0010, 8'h7F, 4'b0001};
    ge[0] = 4'b0001; ge[1] = 4'b0010; ge[2] = 4'b0100; ge[3] = 4'b1000; ge[4] = 4'b0001;

    rst1 = 1'b1;
    rst3 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      t_req[s] = '0; t_a[s] = '0; t_b[s] = '0; t_op[s] = '0;
      m_ptr[s] = 0;
    end

    // Reset and quiet idle period
    #10;
    chk("in reset dut1", ob[0], '0);
    chk("in reset dut3", ob[1], '0);
    #10;
    rst1 = 1'b0;
    rst3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d dut1", i), ob[0], '0);
      chk($sformatf("idle%0d dut3", i), ob[1], '0);
    end

    // Directed single operations, pointer walking 0->1->3->0->2->1->2
    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // ALU_LAT=3 latency, then reset abandons an op in flight
    set_core(1, 1, 8'h11, 8'h22, OP_ADD);
    t_req[1] = 4'b0010;
    step();
    chk("lat3 gnt", {ob[1].gnt, ob[1].busy, ob[1].a}, {4'b0010, 1'b1, 8'h11});
    step();
    chk("lat3 rsp e1", ob[1].rsp, 4'b0000);
    step();
    chk("lat3 rsp e2", ob[1].rsp, 4'b0000);
    step();
    chk("lat3 rsp e3", {ob[1].rsp, ob[1].result, ob[1].flags}, {4'b0010, 8'h33, 4'b0000});
    t_req[1] = '0;
    step();
    chk("lat3 idle", {ob[1].gnt, ob[1].busy}, 5'b0);
    set_core(1, 1, 8'h44, 8'h01, OP_SUB);
    t_req[1] = 4'b0010;
    step();
    chk("abort gnt", ob[1].gnt, 4'b0010);
    step();
    #2;
    rst3 = 1'b1;
    #1;
    chk("abort async clear", ob[1], '0);
    t_req[1] = '0;
    @(negedge clk);
    rst3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ob[1].rsp != 0 || ob[1].busy) seen = 1'b1;
    end
    chk("abort no rsp after release", seen, 1'b0);

    // All four cores requesting: strict rotation, three cycles apart
    do_reset();
    t_a[0] = 32'h0403_0201; t_b[0] = 32'h0101_0101; t_op[0] = '0;
    t_req[0] = 4'b1111;
    ng = 0; prev = '0; raise = '0;
    for (int i = 0; i < 5; i++) begin gl[i] = '0; gc[i] = 0; end
    for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
      step();
      t_req[0] = t_req[0] | raise;
      raise = '0;
      if (ob[0].gnt != 0 && prev == 0) begin
        gl[ng] = ob[0].gnt;
        gc[ng] = cyc;
        ng++;
      end
      prev = ob[0].gnt;
      if (ob[0].rsp != 0) begin
        t_req[0] = t_req[0] & ~ob[0].rsp;
        raise = ob[0].rsp;
      end
    end
    chk("rotation grant count", ng, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rotation grant %0d", i), gl[i], ge[i]);
    for (int i = 1; i < 5; i++) chk($sformatf("rotation spacing %0d", i), gc[i] - gc[i-1], 3);
    t_req[0] = '0;
    step(); step(); step();

    // Request dropped right after grant; operands changed after latching
    set_core(0, 3, 8'h7F, 8'h80, OP_ADD);
    t_req[0] = 4'b1000;
    step();
    chk("drop gnt", ob[0].gnt, 4'b1000);
    t_req[0] = '0;
    set_core(0, 3, 8'h01, 8'h01, OP_SUB);
    step();
    chk("drop rsp", {ob[0].rsp, ob[0].result, ob[0].flags, ob[0].a}, {4'b1000, 8'hFF, 4'b1000, 8'h7F});
    step();
    chk("drop idle", {ob[0].gnt, ob[0].rsp, ob[0].busy}, 9'b0);
    step();
    chk("drop stays idle", {ob[0].gnt, ob[0].busy}, 5'b0);

    // Randomised traffic on both latencies
    do_reset();
    run_rand(0, 1, 40);
    run_rand(1, 3, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
